axi4_lite_master: RTL
=====================

# axi4_lite_master

AXI4-Lite master bridge that converts a simple single-beat command/response interface into AXI4-Lite write and read transactions. It sits directly upstream of `axi4_lite_slave`, driving all five of its channels, so that on-chip logic can access the slave's register file without hand-sequencing handshakes. It has one outstanding transaction at a time, holds all AXI valid/address/data signals stable until each handshake completes, and returns the response (BRESP or RDATA/RRESP) on a held response port.

## Interface
- `addr_width`, 3, AXI and command address width
- `data_width`, 32, data width
- `strb_width`, 4, write strobe width (data_width/8)
- `aclk`  in  1  clock; all logic on rising edge
- `aresetn`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  addr_width  target address
- `cmd_wdata`  in  data_width  write data
- `cmd_wstrb`  in  strb_width  write byte strobes
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_write`  out  1  response belongs to a write
- `rsp_rdata`  out  data_width  read data (0 for writes)
- `rsp_resp`  out  2  BRESP or RRESP
- `awaddr`  out  addr_width; `awprot`  out  1 (tied 0); `awvalid`  out  1; `awready`  in  1
- `wdata`  out  data_width; `wstrb`  out  strb_width; `wvalid`  out  1; `wready`  in  1
- `bresp`  in  2; `bvalid`  in  1; `bready`  out  1
- `araddr`  out  addr_width; `arprot`  out  1 (tied 0); `arvalid`  out  1; `arready`  in  1
- `rdata`  in  data_width; `rresp`  in  2; `rvalid`  in  1; `rready`  out  1

## Operation
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP. Reset state IDLE.
- `cmd_ready` = (state == IDLE). On accept, latch addr/wdata/wstrb/write into holding regs; awaddr/araddr/wdata/wstrb are driven from these regs and stay stable for the transaction.
- IDLE -> WADDR_DATA (write) or RADDR (read) on accept. Set `awvalid` and `wvalid` together (write) or `arvalid` (read).
- WADDR_DATA: AW and W complete independently. `awvalid` clears on the edge where awvalid&awready; `wvalid` clears on wvalid&wready; per-channel done flags record completion. When both are done (including the same edge), go to WRESP with `bready`=1.
- WRESP: on bvalid&bready, capture bresp into `rsp_resp`, set `rsp_write`=1, `rsp_rdata`=0, clear `bready`, go to RSP.
- RADDR: `arvalid` held until arvalid&arready, then clear and go to RDATA with `rready`=1.
- RDATA: on rvalid&rready, capture rdata/rresp, set `rsp_write`=0, clear `rready`, go to RSP.
- RSP: `rsp_valid`=1 with stable payload until rsp_valid&rsp_ready, then go to IDLE (`cmd_ready` is high the following cycle).
- Responses are passed through unmodified (SLVERR/DECERR reported, no retry).
- No AXI valid is ever deasserted before its handshake.

## Timing
- All outputs are registered except `cmd_ready` (decoded from state).
- Reset values: all valids, `bready`, `rready`, `rsp_valid` = 0; `rsp_rdata`, `rsp_resp`, `rsp_write`, addr/data/strb outputs = 0; prot = 0; `cmd_ready` = 1.
- Zero-wait slave, write: accept at edge 0; awvalid/wvalid high cycle 1; bready high cycle 2; bvalid seen in cycle 2 gives `rsp_valid` cycle 3.
- Zero-wait slave, read: arvalid in cycle 1, rready in cycle 2, `rsp_valid` in cycle 3.
- Each wait cycle on any channel adds exactly one cycle. A held `rsp_ready`=0 stalls in RSP indefinitely.
- An asynchronous reset assertion mid-transaction immediately returns all outputs to reset values and the state to IDLE. The in-flight command is lost with no response.

## Test plan
- Reset: assert aresetn=0 mid-simulation -> all outputs take reset values, cmd_ready=1.
- Write addr 3'd1, data 32'd100, strb 4'hF, slave ready immediately -> awvalid&wvalid in cycle 1, bready cycle 2, rsp_valid cycle 3 with rsp_write=1, rsp_resp=2'b00.
- Write addr 3'd2, data 32'd200; wready immediate, awready delayed 3 cycles -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, bready asserts only after AW completes.
- Read addr 3'd1, rvalid delayed 2 cycles with rdata 32'hDEADBEEF -> rready held until rvalid, rsp_rdata=32'hDEADBEEF, rsp_write=0.
- Read with rresp=2'b10, rsp_ready held low 5 cycles -> rsp_valid and payload stable 5+ cycles, cmd_ready=0 throughout, IDLE after handshake.
- Reset asserted while awvalid high waiting on awready -> awvalid/wvalid drop immediately, no rsp_valid; next command proceeds normally.

Source files
------------

// File: rtl/axi4_lite_master_if.sv
// rtl/axi4_lite_master_if.sv - command/response port and five AXI4-Lite channels of the master bridge
// master modport is the bridge side; slave modport is the command source plus AXI slave side.
interface axi4_lite_master_if #(
   parameter int addr_width = 3,
   parameter int data_width = 32,
   parameter int strb_width = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [addr_width-1:0] cmd_addr;
   logic [data_width-1:0] cmd_wdata;
   logic [strb_width-1:0] cmd_wstrb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [data_width-1:0] rsp_rdata;
   logic [1:0]            rsp_resp;

   logic [addr_width-1:0] awaddr;
   logic                  awprot;
   logic                  awvalid;
   logic                  awready;

   logic [data_width-1:0] wdata;
   logic [strb_width-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;

   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [addr_width-1:0] araddr;
   logic                  arprot;
   logic                  arvalid;
   logic                  arready;

   logic [data_width-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
      output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
      input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready
   );
endinterface

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding command/response to AXI4-Lite master bridge
// Every bus output is a register except cmd_ready, which decodes the IDLE state.
module axi4_lite_master #(
   parameter int addr_width = 3,
   parameter int data_width = 32,
   parameter int strb_width = 4
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   axi4_lite_master_if.master   bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_WADDR_DATA,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_RSP
   } state_t;

   state_t                r_state;
   logic [addr_width-1:0] r_addr;
   logic [data_width-1:0] r_wdata;
   logic [strb_width-1:0] r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic                  r_rsp_write;
   logic [data_width-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;

   // A channel counts as done on the very edge its handshake fires.
   logic w_aw_done;
   logic w_w_done;
   assign w_aw_done = r_aw_done | (r_awvalid & bus.awready);
   assign w_w_done  = r_w_done  | (r_wvalid  & bus.wready);

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_write = r_rsp_write;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_resp  = r_rsp_resp;
   assign bus.awaddr    = r_addr;
   assign bus.awprot    = 1'b0;
   assign bus.awvalid   = r_awvalid;
   assign bus.wdata     = r_wdata;
   assign bus.wstrb     = r_wstrb;
   assign bus.wvalid    = r_wvalid;
   assign bus.bready    = r_bready;
   assign bus.araddr    = r_addr;
   assign bus.arprot    = 1'b0;
   assign bus.arvalid   = r_arvalid;
   assign bus.rready    = r_rready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_addr    <= bus.cmd_addr;
                  r_wdata   <= bus.cmd_wdata;
                  r_wstrb   <= bus.cmd_wstrb;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  if (bus.cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= S_WADDR_DATA;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_RADDR;
                  end
               end
            end
            S_WADDR_DATA: begin
               if (r_awvalid && bus.awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (r_wvalid && bus.wready) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (bus.bvalid) begin
                  r_rsp_resp  <= bus.bresp;
                  r_rsp_write <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= 1'b1;
                  r_bready    <= 1'b0;
                  r_state     <= S_RSP;
               end
            end
            S_RADDR: begin
               if (bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (bus.rvalid) begin
                  r_rsp_resp  <= bus.rresp;
                  r_rsp_rdata <= bus.rdata;
                  r_rsp_write <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rready    <= 1'b0;
                  r_state     <= S_RSP;
               end
            end
            S_RSP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
